// File: rtl/gpio_expander_pkg.sv
// Shared frame layout, register map, select codes and bank register-set type.
package gpio_expander_pkg;

  localparam int unsigned BANK_NUM    = 2;
  localparam int unsigned DATA_WIDTH  = 16;
  localparam int unsigned PDATA_WIDTH = 8;
  localparam int unsigned ADDR_WIDTH  = 7;
  localparam int unsigned PADDR_WIDTH = 3;
  localparam int unsigned SEL_WIDTH   = 2;
  localparam int unsigned CNT_WIDTH   = $clog2(DATA_WIDTH);

  // Frame field positions (bit numbers within the 16-bit frame)
  localparam int unsigned FLD_W        = 15;
  localparam int unsigned FLD_SEL_LSB  = 13;
  localparam int unsigned FLD_ADDR_LSB = 10;
  localparam int unsigned FLD_DATA_MSB = 7;

  // Header bits 15:9 sit at the bottom of the RX shifter after ADDR_WIDTH edges
  localparam int unsigned HDR_SHIFT = DATA_WIDTH - ADDR_WIDTH;

  localparam logic [PADDR_WIDTH-1:0] ADDR_OUT = 3'b000;
  localparam logic [PADDR_WIDTH-1:0] ADDR_DIR = 3'b001;
  localparam logic [PADDR_WIDTH-1:0] ADDR_INV = 3'b010;
  localparam logic [PADDR_WIDTH-1:0] ADDR_IN  = 3'b100;

  localparam logic [SEL_WIDTH-1:0] SEL_BANK0 = 2'b01;
  localparam logic [SEL_WIDTH-1:0] SEL_BANK1 = 2'b10;
  localparam logic [SEL_WIDTH-1:0] SEL_CODE [BANK_NUM] = '{SEL_BANK0, SEL_BANK1};

  typedef struct packed {
    logic [PDATA_WIDTH-1:0] out_lvl;
    logic [PDATA_WIDTH-1:0] dir;
    logic [PDATA_WIDTH-1:0] inv;
  } bank_regs_t;

endpackage

// File: rtl/gpio_bank.sv
// One 8-pad bank: OUT/DIR/INV registers, pad tristate and polarity-corrected input.
// INV_REG_EN: when defined the INV register exists; otherwise INV reads as zero.
module gpio_bank
  import gpio_expander_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wr_en,
  input  logic [PADDR_WIDTH-1:0] i_addr,
  input  logic [PDATA_WIDTH-1:0] i_data,
  output bank_regs_t             o_regs,
  output logic [PDATA_WIDTH-1:0] o_in_c,
  inout  wire  [PDATA_WIDTH-1:0] io_pad
);

  logic [PDATA_WIDTH-1:0] r_out;
  logic [PDATA_WIDTH-1:0] r_dir;
  logic [PDATA_WIDTH-1:0] w_inv;

`ifdef INV_REG_EN
  logic [PDATA_WIDTH-1:0] r_inv;

  // Writable register file including polarity invert
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out <= '0;
      r_dir <= '0;
      r_inv <= '0;
    end else if (i_wr_en) begin
      case (i_addr)
        ADDR_OUT: r_out <= i_data;
        ADDR_DIR: r_dir <= i_data;
        ADDR_INV: r_inv <= i_data;
        default:  ;
      endcase
    end
  end

  assign w_inv = r_inv;
`else
  // Writable register file; address 010 is reserved in this build
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out <= '0;
      r_dir <= '0;
    end else if (i_wr_en) begin
      case (i_addr)
        ADDR_OUT: r_out <= i_data;
        ADDR_DIR: r_dir <= i_data;
        default:  ;
      endcase
    end
  end

  assign w_inv = '0;
`endif

  assign o_regs = '{out_lvl: r_out, dir: r_dir, inv: w_inv};

  // Live resolved pad value, including externally driven pads
  assign o_in_c = io_pad ^ w_inv;

  for (genvar i = 0; i < int'(PDATA_WIDTH); i++) begin : g_pad
    assign io_pad[i] = r_dir[i] ? r_out[i] : 1'bz;
  end

endmodule

// File: rtl/gpio_expander.sv
// SPI mode-0 slave GPIO expander: frame shifter, bit counter, decode and read mux.
// INV_REG_EN: enables the per-bank INV register (handled inside gpio_bank).
module gpio_expander
  import gpio_expander_pkg::*;
(
  input  logic                              sclk,
  input  logic                              resetn,
  input  logic                              ss,
  input  logic                              mosi,
  output logic                              miso,
  inout  wire  [BANK_NUM*PDATA_WIDTH-1:0]   pad
);

  localparam logic [CNT_WIDTH-1:0] CNT_HDR  = CNT_WIDTH'(ADDR_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-2:0]  r_rx;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [PDATA_WIDTH-1:0] r_tx;
  logic                   r_miso;

  logic                   w_hdr_w;
  logic [SEL_WIDTH-1:0]   w_hdr_sel;
  logic [PADDR_WIDTH-1:0] w_hdr_addr;
  logic [SEL_WIDTH-1:0]   w_cm_sel;
  logic [PADDR_WIDTH-1:0] w_cm_addr;
  logic [PDATA_WIDTH-1:0] w_cm_data;
  logic [PDATA_WIDTH-1:0] w_rd_data;
  logic [BANK_NUM-1:0]    w_wr_en;
  bank_regs_t             w_regs [BANK_NUM];
  logic [PDATA_WIDTH-1:0] w_in_c [BANK_NUM];

  // Header view while sampling bit 8; commit view while sampling bit 0
  assign w_hdr_w    = r_rx[FLD_W - HDR_SHIFT];
  assign w_hdr_sel  = r_rx[FLD_SEL_LSB - HDR_SHIFT +: SEL_WIDTH];
  assign w_hdr_addr = r_rx[FLD_ADDR_LSB - HDR_SHIFT +: PADDR_WIDTH];
  assign w_cm_sel   = r_rx[FLD_SEL_LSB - 1 +: SEL_WIDTH];
  assign w_cm_addr  = r_rx[FLD_ADDR_LSB - 1 +: PADDR_WIDTH];
  assign w_cm_data  = {r_rx[FLD_DATA_MSB-1:0], mosi};

  // Read mux: selected bank register, zero for writes and unmapped selects/addresses
  always_comb begin
    w_rd_data = '0;
    if (!w_hdr_w) begin
      for (int unsigned b = 0; b < BANK_NUM; b++) begin
        if (w_hdr_sel == SEL_CODE[b]) begin
          case (w_hdr_addr)
            ADDR_OUT: w_rd_data = w_regs[b].out_lvl;
            ADDR_DIR: w_rd_data = w_regs[b].dir;
            ADDR_INV: w_rd_data = w_regs[b].inv;
            ADDR_IN:  w_rd_data = w_in_c[b];
            default:  w_rd_data = '0;
          endcase
        end
      end
    end
  end

  // Write strobe per bank on the 16th rising edge of a complete frame
  always_comb begin
    w_wr_en = '0;
    for (int unsigned b = 0; b < BANK_NUM; b++) begin
      w_wr_en[b] = !ss && (r_cnt == CNT_LAST) && r_rx[FLD_W - 1] &&
                   (w_cm_sel == SEL_CODE[b]);
    end
  end

  // RX shifter, bit counter and TX shifter; ss high discards any partial frame
  always_ff @(posedge sclk) begin
    if (resetn || ss) begin
      r_rx  <= '0;
      r_cnt <= '0;
      r_tx  <= '0;
    end else begin
      r_rx  <= {r_rx[DATA_WIDTH-3:0], mosi};
      r_cnt <= r_cnt + CNT_WIDTH'(1);
      if (r_cnt == CNT_HDR) begin
        r_tx <= w_rd_data;
      end else begin
        r_tx <= {r_tx[PDATA_WIDTH-2:0], 1'b0};
      end
    end
  end

  // miso launches on falling sclk so it is stable for the host's rising-edge sample
  always_ff @(negedge sclk) begin
    if (resetn || ss) begin
      r_miso <= 1'b0;
    end else begin
      r_miso <= r_tx[PDATA_WIDTH-1];
    end
  end

  assign miso = r_miso & ~ss;

  for (genvar b = 0; b < int'(BANK_NUM); b++) begin : g_bank
    gpio_bank u_bank (
      .i_clk   (sclk),
      .i_rst   (resetn),
      .i_wr_en (w_wr_en[b]),
      .i_addr  (w_cm_addr),
      .i_data  (w_cm_data),
      .o_regs  (w_regs[b]),
      .o_in_c  (w_in_c[b]),
      .io_pad  (pad[b*PDATA_WIDTH +: PDATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_gpio_expander.sv
// Self-checking bench for gpio_expander: scoreboarded SPI frames plus pad checks.
module tb_gpio_expander;
  import gpio_expander_pkg::*;

  logic        sclk   = 1'b0;
  logic        resetn = 1'b1;
  logic        ss     = 1'b1;
  logic        mosi   = 1'b0;
  wire         miso;
  wire  [15:0] pad;

  logic [15:0] tb_ext = 16'h005A;
  logic [15:0] tb_en;
  logic [7:0]  m_out [2];
  logic [7:0]  m_dir [2];
  logic [7:0]  m_inv [2];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] sb_q [$];

  // Bench drives every pad the DUT leaves undriven (acts as the pull)
  assign tb_en = ~{m_dir[1], m_dir[0]};
  for (genvar i = 0; i < 16; i++) begin : g_drv
    assign pad[i] = tb_en[i] ? tb_ext[i] : 1'bz;
  end

  gpio_expander dut (
    .sclk   (sclk),
    .resetn (resetn),
    .ss     (ss),
    .mosi   (mosi),
    .miso   (miso),
    .pad    (pad)
  );

  always #5 sclk = ~sclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic w, input logic [1:0] sel,
                                     input logic [2:0] addr, input logic [7:0] d);
    return {w, sel, addr, 2'b00, d};
  endfunction

  function automatic logic [15:0] model_pad();
    logic [15:0] dir, out;
    dir = {m_dir[1], m_dir[0]};
    out = {m_out[1], m_out[0]};
    return (dir & out) | (~dir & tb_ext);
  endfunction

  function automatic logic [7:0] model_rd(input logic [1:0] sel, input logic [2:0] addr);
    int          b;
    logic [15:0] p;
    logic [7:0]  v;
    if (sel != SEL_BANK0 && sel != SEL_BANK1) return 8'h00;
    b = (sel == SEL_BANK1) ? 1 : 0;
    p = model_pad();
    v = 8'h00;
    case (addr)
      3'b000: v = m_out[b];
      3'b001: v = m_dir[b];
`ifdef INV_REG_EN
      3'b010: v = m_inv[b];
      3'b100: v = p[b*8 +: 8] ^ m_inv[b];
`else
      3'b100: v = p[b*8 +: 8];
`endif
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  task automatic model_wr(input logic [15:0] f);
    int b;
    if (!f[15]) return;
    if (f[14:13] != SEL_BANK0 && f[14:13] != SEL_BANK1) return;
    b = (f[14:13] == SEL_BANK1) ? 1 : 0;
    case (f[12:10])
      3'b000: m_out[b] = f[7:0];
      3'b001: m_dir[b] = f[7:0];
`ifdef INV_REG_EN
      3'b010: m_inv[b] = f[7:0];
`endif
      default: ;
    endcase
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_out[b] = 8'h00;
      m_dir[b] = 8'h00;
      m_inv[b] = 8'h00;
    end
  endtask

  // Shift nbits of a frame; a complete frame updates the model at the commit edge
  task automatic xfer(input logic [15:0] tx, input int nbits, input bit keep_ss,
                      output logic [15:0] rx);
    rx = '0;
    if (ss) @(negedge sclk);
    ss   = 1'b0;
    mosi = tx[15];
    for (int i = 0; i < nbits; i++) begin
      @(posedge sclk);
      if (i == 15) model_wr(tx);
      #2;
      rx[15-i] = miso;
      @(negedge sclk);
      if (i < 15) mosi = tx[14-i];
      else        mosi = 1'b0;
    end
    if (!keep_ss) ss = 1'b1;
  endtask

  task automatic frame(input string tag, input logic [15:0] tx, input bit keep_ss);
    logic [15:0] rx;
    logic [15:0] exp;
    exp = tx[15] ? 16'h0000 : {8'h00, model_rd(tx[14:13], tx[12:10])};
    sb_q.push_back(exp);
    xfer(tx, 16, keep_ss, rx);
    check($sformatf("%s tx=%h", tag, tx), rx, sb_q.pop_front());
  endtask

  logic [15:0] rx_dummy;

  initial begin
    model_reset();
    resetn = 1'b1;
    repeat (3) @(posedge sclk);
    @(negedge sclk);
    resetn = 1'b0;
    #1;
    check("reset_miso", 16'(miso), 16'h0000);
    check("reset_pad", pad, model_pad());
    frame("reset_out0", mk(1'b0, SEL_BANK0, ADDR_OUT, 8'h00), 1'b0);
    frame("reset_dir1", mk(1'b0, SEL_BANK1, ADDR_DIR, 8'h00), 1'b0);

    // DIR bank 0 all outputs, OUT still zero
    frame("wr_dir0", mk(1'b1, SEL_BANK0, ADDR_DIR, 8'hFF), 1'b0);
    frame("rd_dir0", mk(1'b0, SEL_BANK0, ADDR_DIR, 8'h00), 1'b0);
    #1;
    check("pad_dir0_out0", pad, model_pad());

    // INV bank 1, floating pads pulled low
    tb_ext = 16'h005A;
    frame("wr_inv1", mk(1'b1, SEL_BANK1, ADDR_INV, 8'hFF), 1'b0);
    frame("rd_inv1", mk(1'b0, SEL_BANK1, ADDR_INV, 8'h00), 1'b0);
    frame("rd_in1_inv", mk(1'b0, SEL_BANK1, ADDR_IN, 8'h00), 1'b0);

    // OUT bank 0 high, read back through IN
    frame("wr_out0", mk(1'b1, SEL_BANK0, ADDR_OUT, 8'hFF), 1'b0);
    #1;
    check("pad_out0_ff", pad, model_pad());
    frame("rd_in0", mk(1'b0, SEL_BANK0, ADDR_IN, 8'h00), 1'b0);

    // Externally driven bank 1
    frame("wr_inv1_zero", mk(1'b1, SEL_BANK1, ADDR_INV, 8'h00), 1'b0);
    tb_ext = 16'hA55A;
    frame("rd_in1_ext", mk(1'b0, SEL_BANK1, ADDR_IN, 8'h00), 1'b0);

    // Aborted write after 9 bits
    xfer(mk(1'b1, SEL_BANK0, ADDR_OUT, 8'h12), 9, 1'b0, rx_dummy);
    #1;
    check("miso_idle", 16'(miso), 16'h0000);
    frame("rd_out0_abort", mk(1'b0, SEL_BANK0, ADDR_OUT, 8'h00), 1'b0);

    // Invalid select, reserved address, read-only IN
    frame("wr_sel11", mk(1'b1, 2'b11, ADDR_OUT, 8'h3C), 1'b0);
    frame("wr_rsv101", mk(1'b1, SEL_BANK0, 3'b101, 8'h3C), 1'b0);
    frame("wr_in0", mk(1'b1, SEL_BANK0, ADDR_IN, 8'h3C), 1'b0);
    frame("rd_sel11", mk(1'b0, 2'b11, ADDR_OUT, 8'h00), 1'b0);
    frame("rd_sel00", mk(1'b0, 2'b00, ADDR_DIR, 8'h00), 1'b0);
    frame("rd_rsv101", mk(1'b0, SEL_BANK0, 3'b101, 8'h00), 1'b0);
    frame("rd_rsv011", mk(1'b0, SEL_BANK0, 3'b011, 8'h00), 1'b0);
    frame("rd_out0_kept", mk(1'b0, SEL_BANK0, ADDR_OUT, 8'h00), 1'b0);
    frame("rd_out1_kept", mk(1'b0, SEL_BANK1, ADDR_OUT, 8'h00), 1'b0);

    // Back-to-back frames with ss held low
    frame("b2b_wr_out1", mk(1'b1, SEL_BANK1, ADDR_OUT, 8'h5A), 1'b1);
    frame("b2b_wr_dir1", mk(1'b1, SEL_BANK1, ADDR_DIR, 8'h0F), 1'b1);
    frame("b2b_rd_out1", mk(1'b0, SEL_BANK1, ADDR_OUT, 8'h00), 1'b1);
    frame("b2b_rd_in1", mk(1'b0, SEL_BANK1, ADDR_IN, 8'h00), 1'b0);
    #1;
    check("pad_b2b", pad, model_pad());

    // Random traffic
    for (int n = 0; n < 24; n++) begin
      logic [15:0] f;
      f = 16'($urandom);
      if (n % 4 == 0) tb_ext = 16'($urandom);
      frame("rand", f, 1'b0);
      #1;
      check("pad_rand", pad, model_pad());
    end

    // Reset during a frame: no commit, registers to reset values
    frame("pre_rst_dir0", mk(1'b1, SEL_BANK0, ADDR_DIR, 8'hF0), 1'b0);
    xfer(mk(1'b1, SEL_BANK0, ADDR_OUT, 8'h77), 10, 1'b1, rx_dummy);
    resetn = 1'b1;
    @(posedge sclk);
    model_reset();
    @(negedge sclk);
    resetn = 1'b0;
    ss     = 1'b1;
    #1;
    check("pad_after_rst", pad, model_pad());
    frame("rd_out0_rst", mk(1'b0, SEL_BANK0, ADDR_OUT, 8'h00), 1'b0);
    frame("rd_dir0_rst", mk(1'b0, SEL_BANK0, ADDR_DIR, 8'h00), 1'b0);
    frame("rd_inv1_rst", mk(1'b0, SEL_BANK1, ADDR_INV, 8'h00), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_expander.md
# gpio_expander

SPI-slave GPIO expander providing 16 bidirectional pads in two 8-bit banks. A host reaches it over a 16-bit SPI mode-0 frame, MSB first, carrying a write/read flag, bank select, register address and 8-bit data. Per-bank registers set output level, pad direction and input polarity, and report the live pad state. The block sits at chip boundary, between the host SPI port and the GPIO pads.

## Interface
- BANK_NUM, 2: number of pad banks.
- DATA_WIDTH, 16: SPI frame length in bits.
- PDATA_WIDTH, 8: pads per bank and register width.
- ADDR_WIDTH, 7: header width (frame bits 15:9) excluding the reserved bit.
- PADDR_WIDTH, 3: register address width.
- sclk  input  1  SPI clock and sole block clock; idles low.
- resetn  input  1  Synchronous, active-high reset (asserted = 1 despite the name), sampled on rising sclk.
- ss  input  1  Active-low slave select.
- mosi  input  1  Serial data in.
- miso  output  1  Serial data out; 0 whenever ss = 1.
- pad  inout  16  GPIO pads; bank 0 = pad[7:0], bank 1 = pad[15:8].

## Operation
- Frame fields: bit 15 W (1 = write, 0 = read); bits 14:13 SEL; bits 12:10 ADDR; bits 9:8 reserved, ignored; bits 7:0 DATA.
- SEL = 01 selects bank 0 and SEL = 10 selects bank 1. SEL = 00 or 11: writes are ignored and reads return 0x00.
- Register map per bank:
  - 000 OUT, read/write: output level.
  - 001 DIR, read/write: 1 = output.
  - 010 INV, read/write: input polarity invert.
  - 100 IN, read-only: pad[bank] XOR INV.
  - 011 and 101–111 are reserved: they read 0x00 and ignore writes. Writes to IN are ignored.
- Pad drive: pad[i] = OUT[i] when DIR[i] = 1, otherwise high-Z. IN always reflects the resolved pad value, including externally driven pads.
- Write: the register is updated at the rising edge that samples bit 0 (the 16th bit). The miso response during a write is all zeros.
- Read: the 16-bit response is 0x00 in bits 15:8, then the register value in bits 7:0. The value is captured at the rising edge that samples header bit 8.
- Reset values: OUT, DIR and INV are 0x00 (all pads high-Z); bit counter 0; shift registers 0; miso 0.

## Timing
- Mode 0. mosi is sampled on rising sclk. miso changes on falling sclk and is valid before the next rising edge.
- Bit counter runs 0..15 and wraps to 0 after the 16th rising edge, so back-to-back frames need no idle clocks.
- Any rising sclk with ss = 1 clears the bit counter and both shift registers. A partial frame is discarded and never commits a write.
- Read data is loaded into the TX shifter at the 8th rising edge. miso presents DATA bit 7 after the 8th falling edge, and bit 0 after the 15th falling edge.
- Reset while a frame is in progress aborts the frame: no write commits and registers return to reset values.

## Configuration
- INV_REG_EN:
  - Defined: the INV register exists at address 010, and IN = pad XOR INV.
  - Undefined: address 010 is reserved (reads 0x00, writes ignored), and IN = raw pad value.

## Structure
- Shared package holds the field positions (W, SEL, ADDR, DATA), register address constants (ADDR_OUT, ADDR_DIR, ADDR_INV, ADDR_IN), SEL codes, and a bank register-set struct typedef.
- One sub-module, gpio_bank: holds the OUT/DIR/INV registers and the per-pad tristate for one 8-bit bank. It is instantiated BANK_NUM times.
- The top level holds the SPI shifter, bit counter, decode and read mux.

## Test plan
- Reset, then write SEL = 01, ADDR 001, 0xFF (DIR bank 0), then read it back -> miso frame 0x00FF; pad[7:0] drives OUT = 0x00.
- Write SEL = 10, ADDR 010, 0xFF (INV bank 1); read back -> 0x00FF. Then read SEL = 10, ADDR 100 with pads floating, pulled to 0 -> 0x00FF.
- DIR bank 0 = 0xFF, write SEL = 01, ADDR 000, 0xFF -> pad[7:0] = 0xFF. Read SEL = 01, ADDR 100 -> 0x00FF.
- DIR bank 1 = 0x00, bench drives pad[15:8] = 0xA5, INV = 0x00; read SEL = 10, ADDR 100 -> 0x00A5.
- Raise ss after 9 bits of a write to OUT, then issue a full read of OUT -> old value returned, no commit.
- Write SEL = 11 and to reserved ADDR 101 -> no register changes; reads of both return 0x0000.
